mem_access_unit: RTL and testbench

MEM-stage access controller between the EX/MEM pipeline register and `DATAMEM`, the 32-word memory with a combinational read and a synchronous write. It turns byte, halfword and word load/store requests into word accesses. Sub-word stores run a two-cycle read-modify-write and stall the pipeline. It sign- or zero-extends load data, registers it for write-back, and flags misaligned accesses.

---
 rtl/mem_access_unit.sv | 137 +++++++++++++
 tb/tb_mem_access_unit.sv | 218 +++++++++++++++++++++
 2 files changed

// File: rtl/mem_access_unit.sv
// MEM-stage access controller in front of the 32-word DATAMEM. Loads are extended and
// registered, word stores write directly, and sub-word stores run a two-cycle read-modify-write.
module mem_access_unit (
  input  logic        clk,
  input  logic        rst,
  input  logic        Valid,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [1:0]  Size,
  input  logic        Unsigned,
  input  logic [6:0]  Addr,
  input  logic [31:0] StoreData,
  output logic [4:0]  MemAddress,
  output logic        MemWriteEnable,
  output logic [31:0] MemBusIn,
  input  logic [31:0] MemBusOut,
  output logic [31:0] LoadData,
  output logic        LoadValid,
  output logic        Stall,
  output logic        MisalignFault
);

  localparam logic [1:0] SIZE_BYTE = 2'b00;
  localparam logic [1:0] SIZE_HALF = 2'b01;
  localparam logic [1:0] SIZE_WORD = 2'b10;
  localparam logic [1:0] SIZE_BAD  = 2'b11;

  localparam logic [0:0] IDLE  = 1'b0;
  localparam logic [0:0] MERGE = 1'b1;

  logic [0:0]  state;

  logic [31:0] cap_word;
  logic [4:0]  cap_index;
  logic [1:0]  cap_lane;
  logic        cap_half;
  logic [15:0] cap_data;

  logic        req;
  logic        misaligned;
  logic        fault;
  logic        do_load;
  logic        do_store;
  logic        word_store;
  logic        sub_store;

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [31:0] ld_ext;
  logic [31:0] merge_word;

  // Requests are only looked at in IDLE; in MERGE upstream is still holding the store.
  assign req        = (state == IDLE) && Valid && (MemRead || MemWrite);
  assign misaligned = (Size == SIZE_BAD)
                   || ((Size == SIZE_HALF) && Addr[0])
                   || ((Size == SIZE_WORD) && (Addr[1:0] != 2'b00))
                   || (MemRead && MemWrite);
  assign fault      = req && misaligned;
  assign do_load    = req && !misaligned && MemRead;
  assign do_store   = req && !misaligned && MemWrite;
  assign word_store = do_store && (Size == SIZE_WORD);
  assign sub_store  = do_store && (Size != SIZE_WORD);

  // Load lane selection and extension
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    ld_byte = MemBusOut[7:0];
    case (Addr[1:0])
      2'd1:    ld_byte = MemBusOut[15:8];
      2'd2:    ld_byte = MemBusOut[23:16];
      2'd3:    ld_byte = MemBusOut[31:24];
      default: ld_byte = MemBusOut[7:0];
    endcase
    ld_half = Addr[1] ? MemBusOut[31:16] : MemBusOut[15:0];
    case (Size)
      SIZE_BYTE: ld_ext = {{24{~Unsigned & ld_byte[7]}}, ld_byte};
      SIZE_HALF: ld_ext = {{16{~Unsigned & ld_half[15]}}, ld_half};
      default:   ld_ext = MemBusOut;
    endcase
  end

  // Captured word with the stored lane(s) replaced
  always_comb begin
    merge_word = cap_word;
    if (cap_half) begin
      if (cap_lane[1]) merge_word[31:16] = cap_data;
      else             merge_word[15:0]  = cap_data;
    end else begin
      case (cap_lane)
        2'd0: merge_word[7:0]   = cap_data[7:0];
        2'd1: merge_word[15:8]  = cap_data[7:0];
        2'd2: merge_word[23:16] = cap_data[7:0];
        2'd3: merge_word[31:24] = cap_data[7:0];
        default: merge_word = cap_word;
      endcase
    end
  end

  assign MemAddress     = (state == MERGE) ? cap_index : Addr[6:2];
  assign MemBusIn       = (state == MERGE) ? merge_word : StoreData;
  assign MemWriteEnable = !rst && ((state == MERGE) || word_store);
  assign Stall          = !rst && sub_store;

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    if (rst) begin
      state         <= IDLE;
      // NOTE: capture registers are cleared on reset so a dropped merge leaves no stale word behind.
      cap_word      <= '0;
      cap_index     <= '0;
      cap_lane      <= '0;
      cap_half      <= 1'b0;
      cap_data      <= '0;
      LoadData      <= '0;
      LoadValid     <= 1'b0;
      MisalignFault <= 1'b0;
    end else begin
      LoadValid     <= do_load;
      MisalignFault <= fault;
      if (do_load) LoadData <= ld_ext;
      case (state)
        IDLE: begin
          if (sub_store) begin
            state     <= MERGE;
            cap_word  <= MemBusOut;
            cap_index <= Addr[6:2];
            cap_lane  <= Addr[1:0];
            cap_half  <= (Size == SIZE_HALF);
            cap_data  <= StoreData[15:0];
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit: transaction-level model with a reference memory,
// per-cycle output comparison, and literal expectations from the directed vectors.
module tb_mem_access_unit;

  logic        clk;
  logic        rst;
  logic        Valid;
  logic        MemRead;
  logic        MemWrite;
  logic [1:0]  Size;
  logic        Unsigned;
  logic [6:0]  Addr;
  logic [31:0] StoreData;
  logic [4:0]  MemAddress;
  logic        MemWriteEnable;
  logic [31:0] MemBusIn;
  logic [31:0] MemBusOut;
  logic [31:0] LoadData;
  logic        LoadValid;
  logic        Stall;
  logic        MisalignFault;

  mem_access_unit dut (
    .clk(clk), .rst(rst), .Valid(Valid), .MemRead(MemRead), .MemWrite(MemWrite),
    .Size(Size), .Unsigned(Unsigned), .Addr(Addr), .StoreData(StoreData),
    .MemAddress(MemAddress), .MemWriteEnable(MemWriteEnable), .MemBusIn(MemBusIn),
    .MemBusOut(MemBusOut), .LoadData(LoadData), .LoadValid(LoadValid),
    .Stall(Stall), .MisalignFault(MisalignFault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] init_word(input int i);
    return (i == 6) ? 32'hFFFF_FFEF : 32'(i + 4);
  endfunction

  // DATAMEM: combinational read, synchronous write
  logic [31:0] dmem [32];
  logic        mem_load;
  always @(posedge clk) begin
    if (mem_load) begin
      for (int i = 0; i < 32; i++) dmem[i] <= init_word(i);
    end else if (MemWriteEnable) begin
      dmem[MemAddress] <= MemBusIn;
    end
  end
  assign MemBusOut = dmem[MemAddress];

  logic [31:0] ref_mem [32];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Expectations for the current cycle and registered results pending for the next one
  logic        chk_en = 1'b0;
  logic        exp_stall = 1'b0, exp_we = 1'b0, exp_addr_chk = 1'b0;
  logic [4:0]  exp_addr = '0;
  logic [31:0] exp_bus = '0;
  logic        exp_lv = 1'b0, exp_ldchk = 1'b0, exp_mf = 1'b0;
  logic [31:0] exp_ld = '0;
  logic        pend_lv = 1'b0, pend_ldchk = 1'b0, pend_mf = 1'b0;
  logic [31:0] pend_ld = '0;

  always @(negedge clk) begin
    if (chk_en) begin
      check("stall", 32'(Stall), 32'(exp_stall));
      check("write_enable", 32'(MemWriteEnable), 32'(exp_we));
      if (exp_addr_chk) check("mem_address", 32'(MemAddress), 32'(exp_addr));
      if (exp_we) check("mem_bus_in", MemBusIn, exp_bus);
      check("load_valid", 32'(LoadValid), 32'(exp_lv));
      if (exp_ldchk) check("load_data", LoadData, exp_ld);
      check("misalign_fault", 32'(MisalignFault), 32'(exp_mf));
    end
  end

  task automatic drive_cycle(input logic r, v, rd, wr, input logic [1:0] sz, input logic un,
                             input logic [6:0] ad, input logic [31:0] sd,
                             input logic e_stall, e_we, e_addr_chk, input logic [31:0] e_bus,
                             input logic n_lv, n_ldchk, input logic [31:0] n_ld, input logic n_mf);
    @(posedge clk); #1;
    exp_lv = pend_lv; exp_ldchk = pend_ldchk; exp_ld = pend_ld; exp_mf = pend_mf;
    rst = r; Valid = v; MemRead = rd; MemWrite = wr; Size = sz; Unsigned = un;
    Addr = ad; StoreData = sd;
    exp_stall = e_stall; exp_we = e_we; exp_addr_chk = e_addr_chk;
    exp_addr = ad[6:2]; exp_bus = e_bus;
    pend_lv = n_lv; pend_ldchk = n_ldchk; pend_ld = n_ld; pend_mf = n_mf;
  endtask

  task automatic idle();
    drive_cycle(0, 0, 0, 0, 2'b00, 0, 7'd0, 32'd0, 0, 0, 1, 32'd0, 0, 0, 32'd0, 0);
  endtask

  task automatic reset_cycle();
    drive_cycle(1, 0, 0, 0, 2'b00, 0, 7'd0, 32'd0, 0, 0, 0, 32'd0, 0, 1, 32'd0, 0);
  endtask

  // Model of one request: derives every expectation from the reference memory
  task automatic issue(input logic rd, wr, input logic [1:0] sz, input logic un,
                       input logic [6:0] ad, input logic [31:0] sd);
    int          idx, lane, nb;
    logic        bad;
    logic [31:0] w, mask, v, merged;
    idx  = int'(ad[6:2]);
    lane = int'(ad[1:0]);
    nb   = (sz == 2'b00) ? 1 : (sz == 2'b01) ? 2 : 4;
    bad  = (sz == 2'b11) || (sz == 2'b01 && ad[0]) || (sz == 2'b10 && ad[1:0] != 2'b00) || (rd && wr);
    if (!rd && !wr) begin
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 0, 0, 1, 32'd0, 0, 0, 32'd0, 0);
    end else if (bad) begin
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 0, 0, 1, 32'd0, 0, 0, 32'd0, 1);
    end else if (rd) begin
      w    = ref_mem[idx] >> (8 * lane);
      mask = (nb == 1) ? 32'h0000_00FF : (nb == 2) ? 32'h0000_FFFF : 32'hFFFF_FFFF;
      v    = w & mask;
      if (!un && nb < 4 && v[8*nb-1]) v = v | ~mask;
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 0, 0, 1, 32'd0, 1, 1, v, 0);
    end else if (nb == 4) begin
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 0, 1, 1, sd, 0, 0, 32'd0, 0);
      ref_mem[idx] = sd;
    end else begin
      merged = ref_mem[idx];
      for (int b = 0; b < 4; b++)
        if (b >= lane && b < lane + nb) merged[8*b +: 8] = sd[8*(b-lane) +: 8];
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 1, 0, 1, 32'd0, 0, 0, 32'd0, 0);
      drive_cycle(0, 1, rd, wr, sz, un, ad, sd, 0, 1, 1, merged, 0, 0, 32'd0, 0);
      ref_mem[idx] = merged;
    end
  endtask

  initial begin
    rst = 1'b1; Valid = 0; MemRead = 0; MemWrite = 0; Size = 2'b00; Unsigned = 0;
    Addr = '0; StoreData = '0; mem_load = 1'b1;
    for (int i = 0; i < 32; i++) ref_mem[i] = init_word(i);

    reset_cycle();
    chk_en = 1'b1;
    reset_cycle();
    mem_load = 1'b0;
    idle();
    check("reset_load_data", LoadData, 32'h0);
    check("reset_load_valid", 32'(LoadValid), 32'h0);

    // Byte loads, signed then unsigned, back to back
    issue(1, 0, 2'b00, 0, 7'd24, 32'd0);
    issue(1, 0, 2'b00, 1, 7'd24, 32'd0);
    check("lit_byte_signed", LoadData, 32'hFFFF_FFEF);
    idle();
    check("lit_byte_unsigned", LoadData, 32'h0000_00EF);

    // Byte store RMW followed immediately by a load of the same word
    issue(0, 1, 2'b00, 0, 7'd1, 32'hFFFF_FFAB);
    issue(1, 0, 2'b10, 0, 7'd0, 32'd0);
    idle();
    check("lit_rmw_readback", LoadData, 32'h0000_AB04);

    // Halfword store to the upper half, then a single-cycle word store
    issue(0, 1, 2'b01, 0, 7'd6, 32'hCAFE_1234);
    issue(0, 1, 2'b10, 0, 7'd8, 32'hDEAD_BEEF);
    idle();

    // Faulting requests
    issue(1, 0, 2'b10, 0, 7'd2, 32'd0);
    issue(0, 1, 2'b01, 0, 7'd3, 32'h0000_7777);
    check("lit_fault_pulse", 32'(MisalignFault), 32'h1);
    issue(0, 1, 2'b11, 0, 7'd12, 32'h1111_1111);
    issue(1, 1, 2'b00, 0, 7'd16, 32'h2222_2222);
    idle();
    idle();
    check("lit_fault_cleared", 32'(MisalignFault), 32'h0);

    // Reset during MERGE drops the write and clears registered outputs
    issue(1, 0, 2'b00, 1, 7'd24, 32'd0);
    drive_cycle(0, 1, 0, 1, 2'b00, 0, 7'd20, 32'h55, 1, 0, 1, 32'd0, 0, 0, 32'd0, 0);
    drive_cycle(1, 1, 0, 1, 2'b00, 0, 7'd20, 32'h55, 0, 0, 0, 32'd0, 0, 1, 32'd0, 0);
    idle();
    check("lit_rst_load_data", LoadData, 32'h0);
    check("lit_rst_load_valid", 32'(LoadValid), 32'h0);
    check("lit_rst_fault", 32'(MisalignFault), 32'h0);
    issue(1, 0, 2'b10, 0, 7'd20, 32'd0);
    idle();
    check("lit_word5_unchanged", LoadData, 32'h0000_0009);

    // Halfword loads, signed and unsigned, back to back
    issue(1, 0, 2'b01, 0, 7'd26, 32'd0);
    issue(1, 0, 2'b01, 1, 7'd26, 32'd0);
    check("lit_half_signed", LoadData, 32'hFFFF_FFFF);
    idle();
    check("lit_half_unsigned", LoadData, 32'h0000_FFFF);

    // Upper-lane byte store, signed byte load of it, and non-requests
    issue(0, 1, 2'b00, 0, 7'd15, 32'h0000_0080);
    issue(1, 0, 2'b00, 0, 7'd15, 32'd0);
    drive_cycle(0, 0, 1, 1, 2'b11, 0, 7'd5, 32'h3333_3333, 0, 0, 1, 32'd0, 0, 0, 32'd0, 0);
    issue(0, 0, 2'b00, 0, 7'd9, 32'h4444_4444);
    idle();
    idle();

    chk_en = 1'b0;
    check("lit_mem_word0", dmem[0], 32'h0000_AB04);
    check("lit_mem_word1", dmem[1], 32'h1234_0005);
    check("lit_mem_word2", dmem[2], 32'hDEAD_BEEF);
    check("lit_mem_word5", dmem[5], 32'h0000_0009);
    for (int i = 0; i < 32; i++) check($sformatf("mem_word_%0d", i), dmem[i], ref_mem[i]);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
